ro_puf_resp_gen: RTL

Sequencer and response builder directly downstream of the ring-oscillator counter pair.
- Per response bit: clears the counter pair, enables it, waits for either count to saturate (or a timeout), then compares the two frozen counts.
- Accumulates one bit per selected RO pair into an NBITS response word.
- Presents the word on a valid/ready handshake.
- Runs entirely in the system clock domain; counts arrive asynchronously from the RO-clocked counters.

---
 rtl/ro_puf_resp_gen.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ro_puf_resp_gen.sv
// Ring-oscillator PUF response generator.
// Runs the RO counter pair once per response bit, compares the frozen counts
// and builds an NBITS response word, which it presents on a valid/ready handshake.
// Optional build macro: RESP_UNSTABLE_MASK_EN adds the `unstable` output, which
// marks the bits whose count difference is below MARGIN.
module ro_puf_resp_gen #(
    parameter int unsigned CW      = 8,
    parameter int unsigned NBITS   = 16,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 4095
`ifdef RESP_UNSTABLE_MASK_EN
    ,
    parameter int unsigned MARGIN  = 2
`endif
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [CW-1:0]                          cnt_a,
    input  logic [CW-1:0]                          cnt_b,
    output logic                                   ctr_reset,
    output logic                                   ctr_enable,
    output logic [((NBITS > 1) ? $clog2(NBITS) : 1)-1:0] pair_sel,
    output logic                                   busy,
    output logic                                   resp_valid,
    input  logic                                   resp_ready,
    output logic [NBITS-1:0]                       response,
`ifdef RESP_UNSTABLE_MASK_EN
    output logic [NBITS-1:0]                       unstable,
`endif
    output logic                                   timeout_err
);

    localparam int unsigned PW   = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned TMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] CLR_LAST    = TW'(1);
    localparam logic [TW-1:0] RUN_LAST    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [PW-1:0] SEL_LAST    = PW'(NBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_CMP    = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          timeout_hit;
    logic [TW-1:0] timer;
    logic [1:0]    sat_sync;
    logic          sat_raw;
    logic          sat_s;
    logic          bit_val;

    // Saturation flag from the RO-clocked counters; the only count-derived signal used before they freeze
    assign sat_raw = (&cnt_a) | (&cnt_b);
    assign sat_s   = sat_sync[1];
    assign bit_val = (cnt_a > cnt_b);

`ifdef RESP_UNSTABLE_MASK_EN
    localparam logic [CW:0] MARGIN_V = (CW + 1)'(MARGIN);
    logic [CW:0] abs_diff;
    logic        unstable_bit;

    // Magnitude of the count difference, widened so the subtraction cannot wrap
    assign abs_diff     = (cnt_a >= cnt_b) ? ({1'b0, cnt_a} - {1'b0, cnt_b})
                                           : ({1'b0, cnt_b} - {1'b0, cnt_a});
    assign unstable_bit = (abs_diff < MARGIN_V);
`endif

    // Two-flop synchronizer for the asynchronous saturation flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_sync <= 2'b00;
        end else begin
            sat_sync <= {sat_sync[0], sat_raw};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; saturation wins over a coincident timeout
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_CLR;
            end
            S_CLR: begin
                if (timer == CLR_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (sat_s) begin
                    state_nxt = S_SETTLE;
                end else if (timer == RUN_LAST) begin
                    state_nxt   = S_SETTLE;
                    timeout_hit = 1'b1;
                end
            end
            S_SETTLE: begin
                if (timer == SETTLE_LAST) state_nxt = S_CMP;
            end
            S_CMP: begin
                state_nxt = (pair_sel == SEL_LAST) ? S_OUT : S_CLR;
            end
            S_OUT: begin
                if (resp_valid && resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Phase timer, cleared on every state change and parked in IDLE/OUT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if ((state_nxt != state) || (state == S_IDLE) || (state == S_OUT)) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Registered control outputs, decoded from the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr_reset  <= 1'b1;
            ctr_enable <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            ctr_reset  <= (state_nxt == S_IDLE) || (state_nxt == S_CLR);
            ctr_enable <= (state_nxt == S_RUN);
            busy       <= (state_nxt != S_IDLE);
            resp_valid <= (state_nxt == S_OUT);
        end
    end

    // Response word, bit index and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            response    <= '0;
            pair_sel    <= '0;
            timeout_err <= 1'b0;
`ifdef RESP_UNSTABLE_MASK_EN
            unstable    <= '0;
`endif
        end else begin
            if ((state == S_IDLE) && start) begin
                response    <= '0;
                pair_sel    <= '0;
                timeout_err <= 1'b0;
`ifdef RESP_UNSTABLE_MASK_EN
                unstable    <= '0;
`endif
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (state == S_CMP) begin
                response[pair_sel] <= bit_val;
`ifdef RESP_UNSTABLE_MASK_EN
                unstable[pair_sel] <= unstable_bit;
`endif
                if (pair_sel != SEL_LAST) begin
                    pair_sel <= pair_sel + PW'(1);
                end
            end
            if ((state == S_OUT) && resp_valid && resp_ready) begin
                pair_sel <= '0;
            end
        end
    end

endmodule
